// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the MiniMIPS32 pipeline controller: exception codes,
// stall patterns and the default exception vector.
package pipeline_ctrl_pkg;

   localparam int EXC_CODE_WIDTH = 5;
   typedef logic [EXC_CODE_WIDTH-1:0] exc_code_t;

   localparam exc_code_t EC_Int  = 5'h00;
   localparam exc_code_t EC_AdEL = 5'h04;
   localparam exc_code_t EC_AdES = 5'h05;
   localparam exc_code_t EC_Sys  = 5'h08;
   localparam exc_code_t EC_Bp   = 5'h09;
   localparam exc_code_t EC_RI   = 5'h0A;
   localparam exc_code_t EC_Ov   = 5'h0C;
   localparam exc_code_t EC_Eret = 5'h0E;
   localparam exc_code_t EC_None = 5'h10;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   // bit0 PC .. bit5 WB; a request stops its own stage and everything upstream
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

   typedef enum logic {StRun, StRecover} ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall merging, exception/ERET flush sequencing with a
// post-flush recovery window, data-bus timeout and stall-cycle accounting.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR     = EXC_VECTOR_DEFAULT,
   parameter int unsigned RECOVER_CYCLES = 2,
   parameter logic [7:0]  BUS_TMO        = 8'd255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stallreq_if,
   input  logic                      stallreq_id,
   input  logic                      stallreq_ex,
   input  logic                      stallreq_mem,
   input  logic [EXC_CODE_WIDTH-1:0] mem_exc_code,
   input  logic [31:0]               cp0_epc,
   output logic [5:0]                stall,
   output logic                      flush,
   output logic [31:0]               new_pc,
   output logic                      bus_timeout,
   output logic [31:0]               stall_cycles
);

   localparam logic [3:0] REC_LOAD = 4'(RECOVER_CYCLES - 1);
   localparam logic [7:0] TMO_LAST = BUS_TMO - 8'd1;

   ctrl_state_e r_state;
   logic [3:0]  r_rec_cnt;
   logic [7:0]  r_tmo_cnt;
   logic        r_bus_timeout;
   logic [31:0] r_stall_cycles;

   logic [5:0]  w_stall;
   logic        w_flush;
   logic [31:0] w_new_pc;

   // Exceptions are only honoured in RUN; RECOVER holds nothing but bubbles.
   always_comb begin
      w_stall  = STALL_NONE;
      w_flush  = 1'b0;
      w_new_pc = ZeroWord;
      if (!rst) begin
         if (r_state == StRun && mem_exc_code != EC_None) begin
            w_flush  = 1'b1;
            w_new_pc = (mem_exc_code == EC_Eret) ? cp0_epc : EXC_VECTOR;
         end else if (stallreq_mem) begin
            w_stall = STALL_MEM;
         end else if (stallreq_ex) begin
            w_stall = STALL_EX;
         end else if (stallreq_id) begin
            w_stall = STALL_ID;
         end else if (stallreq_if) begin
            w_stall = STALL_IF;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= StRun;
         r_rec_cnt      <= 4'd0;
         r_tmo_cnt      <= 8'd0;
         r_bus_timeout  <= 1'b0;
         r_stall_cycles <= 32'd0;
      end else begin
         case (r_state)
            StRun: begin
               if (w_flush) begin
                  r_state   <= StRecover;
                  r_rec_cnt <= REC_LOAD;
               end
            end
            StRecover: begin
               if (r_rec_cnt == 4'd0) begin
                  r_state <= StRun;
               end else begin
                  r_rec_cnt <= r_rec_cnt - 4'd1;
               end
            end
         endcase

         // Wait-state run is counted modulo BUS_TMO so a stuck bus pulses repeatedly.
         r_bus_timeout <= 1'b0;
         if (stallreq_mem && !w_flush) begin
            if (r_tmo_cnt == TMO_LAST) begin
               r_bus_timeout <= 1'b1;
               r_tmo_cnt     <= 8'd0;
            end else begin
               r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
         end else begin
            r_tmo_cnt <= 8'd0;
         end

         if (w_stall[0] == Stop) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
      end
   end

   assign stall        = w_stall;
   assign flush        = w_flush;
   assign new_pc       = w_new_pc;
   assign bus_timeout  = r_bus_timeout;
   assign stall_cycles = r_stall_cycles;

endmodule
